// File: rtl/retrosoc_uart_pkg.sv
// retrosoc_uart_pkg -- definitions shared by the retroSoC UART receive and
// transmit paths: the frame-walking state enum and the framing constants.
package retrosoc_uart_pkg;

  // Frame-walking states. PARITY is only visited when parity checking is built in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_W     = $clog2(DATA_BITS);
  // Smallest usable bit period in clk cycles; smaller divisors are raised to this.
  localparam int unsigned MIN_DIV   = 4;

endpackage

// File: rtl/retrosoc_sync2.sv
// retrosoc_sync2 -- multi-flop synchronizer for an asynchronous input pin.
// The flops preset to 1 so an idle-high line reads as idle straight out of reset.
//
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset (presets the chain to 1)
//   d_i    asynchronous input
//   q_o    synchronized output, STAGES clk cycles behind d_i
module retrosoc_sync2 #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/retrosoc_uart_rx.sv
// retrosoc_uart_rx -- 8N1 UART receiver for the retroSoC pin wrapper, with a
// one-entry valid/ready holding register towards the SoC bus.
//
// Optional build macro: RETROSOC_UART_RX_PARITY_EN adds a parity bit between
// the data bits and the stop bit (ports parity_odd / parity_err).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clk_div    clk cycles per bit (values below 4 behave as 4), latched per frame
//   rxd        asynchronous serial line, idle high
//   rx_data    last received byte
//   rx_valid   holding register full
//   rx_ready   consumer accepts the byte when rx_valid & rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte landed on a full, unpopped holding register
//   busy       receiver is inside a frame
//   parity_odd / parity_err (macro only): parity sense and one-cycle error pulse
module retrosoc_uart_rx
  import retrosoc_uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
`ifdef RETROSOC_UART_RX_PARITY_EN
  input  logic             parity_odd,
  output logic             parity_err,
`endif
  output logic             busy
);

  logic                 rxs;
  uart_state_e          state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     div_eff;
  logic [BIT_W-1:0]     bitidx_q, bitidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 cnt_zero;

  logic                 stop_hit;
  logic                 deliver;
  logic                 ferr_d;
  logic                 ovr_d;

  logic [7:0]           rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

`ifdef RETROSOC_UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 par_bad;
  logic                 perr_d;
  logic                 parity_err_q;
`endif

  retrosoc_sync2 #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rxd),
    .q_o  (rxs)
  );

  always_comb begin
    div_eff = clk_div;
    if (clk_div < DIV_W'(MIN_DIV)) begin
      div_eff = DIV_W'(MIN_DIV);
    end
  end

  assign cnt_zero = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_W'(MIN_DIV);
      bitidx_q <= '0;
      shreg_q  <= '0;
`ifdef RETROSOC_UART_RX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
`ifdef RETROSOC_UART_RX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Next-state logic. Every bit is sampled when cnt reaches zero; the start
  // bit uses a half-period count so later samples land mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
`ifdef RETROSOC_UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rxs) begin
            cnt_d    = div_q - DIV_W'(1);
            bitidx_d = '0;
            state_d  = DATA;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shreg_d[bitidx_q] = rxs;
          cnt_d             = div_q - DIV_W'(1);
          bitidx_d          = bitidx_q + BIT_W'(1);
          if (bitidx_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef RETROSOC_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`ifdef RETROSOC_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          par_d   = rxs;
          cnt_d   = div_q - DIV_W'(1);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop so a start bit right behind this frame is seen.
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: frame verdict at the stop sample, plus busy.
  always_comb begin
    stop_hit = (state_q == STOP) && cnt_zero;
    ferr_d   = stop_hit && !rxs;
`ifdef RETROSOC_UART_RX_PARITY_EN
    par_bad  = (par_q != ((^shreg_q) ^ parity_odd));
    perr_d   = stop_hit && par_bad;
    deliver  = stop_hit && rxs && !par_bad;
`else
    deliver  = stop_hit && rxs;
`endif
    ovr_d    = deliver && rx_valid_q && !rx_ready;
    busy     = (state_q != IDLE);
  end

  // Holding register: a delivery always overwrites, so the newest byte wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RETROSOC_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= ferr_d;
      overrun_q    <= ovr_d;
`ifdef RETROSOC_UART_RX_PARITY_EN
      parity_err_q <= perr_d;
`endif
      if (deliver) begin
        rx_data_q  <= shreg_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef RETROSOC_UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_retrosoc_uart_rx.sv
// Testbench for retrosoc_uart_rx: directed frames plus random 8N1 traffic
// checked against a byte-level model of the holding register.
module tb_retrosoc_uart_rx;

  localparam int unsigned DIV_W       = 16;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] clk_div;
  logic             rxd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;
`ifdef RETROSOC_UART_RX_PARITY_EN
  logic             parity_odd;
  logic             parity_err;
`endif

  retrosoc_uart_rx #(
    .DIV_W      (DIV_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef RETROSOC_UART_RX_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Pulse counters, sampled mid-cycle; a pulse held two cycles counts twice.
  int unsigned fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt <= both_cnt + 1;
`ifdef RETROSOC_UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
  end

  // Reference model of the holding register
  logic       m_valid;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned eff(input int unsigned d);
    return (d < 4) ? 4 : d;
  endfunction

  // Line bits in transmit order from bit 0: start, data LSB first, [parity], stop.
`ifdef RETROSOC_UART_RX_PARITY_EN
  localparam int unsigned NB = 11;
  function automatic logic [10:0] frm(input logic [7:0] b, input logic stop_bit);
    return {stop_bit, (^b) ^ parity_odd, b, 1'b0};
  endfunction
`else
  localparam int unsigned NB = 10;
  function automatic logic [10:0] frm(input logic [7:0] b, input logic stop_bit);
    return {1'b1, stop_bit, b, 1'b0};
  endfunction
`endif

  task automatic send_line(input logic [10:0] f, input int unsigned d);
    for (int unsigned i = 0; i < NB; i++) begin
      rxd = f[i];
      repeat (eff(d)) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic frame_and_check(input logic [7:0] b, input int unsigned d,
                                 input logic stop_ok, input logic par_ok);
    logic [10:0] f;
    int unsigned fe0, ov0, pe0;
    logic        good, exp_ov;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    f = frm(b, stop_ok);
`ifdef RETROSOC_UART_RX_PARITY_EN
    if (!par_ok) f[9] = ~f[9];
`endif
    clk_div = DIV_W'(d);
    send_line(f, d);
    repeat (2 * eff(d) + 4) @(negedge clk);
    good   = stop_ok && par_ok;
    exp_ov = good && m_valid;
    if (good) begin
      m_data  = b;
      m_valid = 1'b1;
    end
    chk("frame_err", fe_cnt - fe0, {31'd0, !stop_ok});
    chk("overrun", ov_cnt - ov0, {31'd0, exp_ov});
`ifdef RETROSOC_UART_RX_PARITY_EN
    chk("parity_err", pe_cnt - pe0, {31'd0, !par_ok});
`endif
    chk("rx_valid", rx_valid, m_valid);
    if (m_valid) chk("rx_data", rx_data, m_data);
    chk("busy_idle", busy, 0);
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    if (m_valid) chk("pop_data_hold", rx_data, m_data);
    m_valid = 1'b0;
    chk("pop_valid", rx_valid, 0);
  endtask

  initial begin
    int unsigned cyc, exp_lat, fe0, ov0, pe0, bcnt, d;
    logic [7:0]  b;
    logic        stop_ok, par_ok;

    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0; clk_div = 16;
    m_valid = 1'b0; m_data = '0;
`ifdef RETROSOC_UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte and its latency from the rxd falling edge
    fe0 = fe_cnt; ov0 = ov_cnt;
    clk_div = 16;
    cyc = 0;
    fork
      send_line(frm(8'hA5, 1'b1), 16);
      begin
        while (rx_valid !== 1'b1 && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    exp_lat = SYNC_STAGES + 8 + 9 * 16 + 1;
    chk("latency", (cyc + 1 >= exp_lat && cyc <= exp_lat + 1) ? exp_lat : cyc, exp_lat);
    repeat (8) @(negedge clk);
    m_valid = 1'b1; m_data = 8'hA5;
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Back-to-back frames with no idle gap and no pop
    pop();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_line(frm(8'h3C, 1'b1), 16);
    send_line(frm(8'hC3, 1'b1), 16);
    repeat (40) @(negedge clk);
    m_valid = 1'b1; m_data = 8'hC3;
    chk("b2b_overrun", ov_cnt - ov0, 1);
    chk("b2b_data", rx_data, 8'hC3);
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_ferr", fe_cnt - fe0, 0);

    // Pop in the very cycle a new byte is delivered
    ov0 = ov_cnt;
    fork
      send_line(frm(8'h81, 1'b1), 16);
      begin
        repeat (4 + 8 + 9 * 16 - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    m_valid = 1'b1; m_data = 8'h81;
    chk("popdel_overrun", ov_cnt - ov0, 0);
    chk("popdel_data", rx_data, 8'h81);
    chk("popdel_valid", rx_valid, 1);

    // Bad stop bit, then a clean frame
    pop();
    frame_and_check(8'h55, 16, 1'b0, 1'b1);
    frame_and_check(8'h0F, 16, 1'b1, 1'b1);

    // Reset at the DATA bit-4 sample; remaining line bits are all high
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_line(frm(8'hF0, 1'b1), 16);
      begin
        repeat (4 + 8 + 5 * 16 - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", rx_data, 0);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_flags", {30'd0, frame_err, overrun}, 0);
        rst = 1'b0;
      end
    join
    m_valid = 1'b0; m_data = '0;
    repeat (40) @(negedge clk);
    chk("midrst_noframe", (fe_cnt - fe0) + (ov_cnt - ov0) + {31'd0, rx_valid}, 0);
    frame_and_check(8'hFF, 16, 1'b1, 1'b1);

    // Start glitch: 3 low cycles
    pop();
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    clk_div = 16;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    bcnt = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    chk("glitch_busy_len", (bcnt >= 6 && bcnt <= 11) ? 9 : bcnt, 9);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

`ifdef RETROSOC_UART_RX_PARITY_EN
    parity_odd = 1'b0;
    frame_and_check(8'h01, 16, 1'b1, 1'b0);
    frame_and_check(8'h01, 16, 1'b0, 1'b0);
`endif

    // Random traffic, including divisors below the minimum
    for (int unsigned n = 0; n < 40; n++) begin
      d       = $urandom_range(0, 12);
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      par_ok  = 1'b1;
`ifdef RETROSOC_UART_RX_PARITY_EN
      parity_odd = 1'($urandom_range(0, 1));
      par_ok     = ($urandom_range(0, 5) != 0);
`endif
      frame_and_check(b, d, stop_ok, par_ok);
      if ($urandom_range(0, 1) == 1) pop();
    end

    chk("flag_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
